// File: rtl/multicycle_dp_pkg.sv
// Shared opcodes, FSM states, ALU operation codes and instruction field positions
// for the multi-cycle data path.
package multicycle_dp_pkg;

    localparam logic [5:0] OP_XOR  = 6'h06;
    localparam logic [5:0] OP_SHL  = 6'h08;
    localparam logic [5:0] OP_ROR  = 6'h0B;
    localparam logic [5:0] OP_LD   = 6'h10;
    localparam logic [5:0] OP_ST   = 6'h11;
    localparam logic [5:0] OP_JMP  = 6'h18;
    localparam logic [5:0] OP_BZ   = 6'h19;
    localparam logic [5:0] OP_BNZ  = 6'h1A;
    localparam logic [5:0] OP_BC   = 6'h1B;
    localparam logic [5:0] OP_BNC  = 6'h1C;
    localparam logic [5:0] OP_ADDI = 6'h20;
    localparam logic [5:0] OP_XORI = 6'h26;
    localparam logic [5:0] OP_NOP  = 6'h3E;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    // Encodings match the low opcode nibble of both the ALU and shift groups.
    typedef enum logic [3:0] {
        ALU_ADD = 4'h0, ALU_ADC = 4'h1, ALU_SUB = 4'h2, ALU_SBB = 4'h3,
        ALU_AND = 4'h4, ALU_OR  = 4'h5, ALU_XOR = 4'h6,
        ALU_SHL = 4'h8, ALU_SHR = 4'h9, ALU_ROL = 4'hA, ALU_ROR = 4'hB
    } alu_op_t;

    function automatic int opc_lsb(input int data_w, input int ra_w);
        return data_w + 2*ra_w;
    endfunction

    function automatic int rd_lsb(input int data_w, input int ra_w);
        return data_w + ra_w;
    endfunction

    function automatic int rs1_lsb(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/mc_reg_file.sv
// General register file: two asynchronous read ports, one synchronous write port,
// whole array cleared by the asynchronous active-low reset.
module mc_reg_file
    import multicycle_dp_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  REG_CNT = 8,
    localparam int RA_W    = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [RA_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RA_W-1:0]   raddr0_i,
    input  logic [RA_W-1:0]   raddr1_i,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o
);

    logic [REG_CNT-1:0][DATA_W-1:0] regs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      regs_q <= '0;
        else if (we_i) regs_q[waddr_i] <= wdata_i;
    end

    assign rdata0_o = regs_q[raddr0_i];
    assign rdata1_o = regs_q[raddr1_i];

endmodule

// File: rtl/multicycle_data_path.sv
// Multi-cycle RISC core: FETCH/DECODE/EXEC/MEM/WB FSM with req/ack memories.
// Optional PERF_COUNTERS_EN adds saturating cycle and retire counters.
module multicycle_data_path
    import multicycle_dp_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  PC_W    = 12,
    parameter int  REG_CNT = 8,
    localparam int RA_W    = $clog2(REG_CNT),
    localparam int INSTR_W = 6 + 2*RA_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               halted,
`ifdef PERF_COUNTERS_EN
    output logic [31:0]        cyc_cnt,
    output logic [31:0]        ret_cnt,
`endif
    output logic               illegal
);

    localparam int OPC_LSB = opc_lsb(DATA_W, RA_W);
    localparam int RD_LSB  = rd_lsb(DATA_W, RA_W);
    localparam int RS1_LSB = rs1_lsb(DATA_W);

    state_t              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [INSTR_W-1:0]  ir_q;
    logic [DATA_W-1:0]   a_q, b_q, res_q, dmem_addr_q, dmem_wdata_q;
    logic                c_q, z_q, imem_req_q, dmem_req_q, dmem_we_q, halted_q, illegal_q;

    logic [5:0]          opc;
    logic [RA_W-1:0]     rd_a, rs1_a, rf_ra1;
    logic [DATA_W-1:0]   imm, rf_rd0, rf_rd1;
    logic                is_alu_rr, is_alu_ri, is_shift, is_alu, is_ld, is_st;
    logic                is_jmp, is_br, is_nop, is_halt, taken;
    logic [PC_W-1:0]     pc_inc, br_tgt, pc_nxt;

    assign opc   = ir_q[OPC_LSB +: 6];
    assign rd_a  = ir_q[RD_LSB +: RA_W];
    assign rs1_a = ir_q[RS1_LSB +: RA_W];
    assign imm   = ir_q[DATA_W-1:0];

    assign is_alu_rr = (opc <= OP_XOR);
    assign is_alu_ri = (opc >= OP_ADDI) && (opc <= OP_XORI);
    assign is_shift  = (opc >= OP_SHL) && (opc <= OP_ROR);
    assign is_alu    = is_alu_rr || is_alu_ri || is_shift;
    assign is_ld     = (opc == OP_LD);
    assign is_st     = (opc == OP_ST);
    assign is_jmp    = (opc == OP_JMP);
    assign is_br     = (opc >= OP_BZ) && (opc <= OP_BNC);
    assign is_nop    = (opc == OP_NOP);
    assign is_halt   = (opc == OP_HALT);

    // Second read port serves rs2 for register-register ALU ops, rd (store data) otherwise.
    assign rf_ra1 = is_alu_rr ? imm[RA_W-1:0] : rd_a;

    mc_reg_file #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (state_q == WB),
        .waddr_i  (rd_a),
        .wdata_i  (res_q),
        .raddr0_i (rs1_a),
        .raddr1_i (rf_ra1),
        .rdata0_o (rf_rd0),
        .rdata1_o (rf_rd1)
    );

    always_comb begin
        taken = 1'b0;
        case (opc)
            OP_BZ:   taken = z_q;
            OP_BNZ:  taken = !z_q;
            OP_BC:   taken = c_q;
            OP_BNC:  taken = !c_q;
            default: taken = 1'b0;
        endcase
    end

    assign pc_inc = pc_q + 1'b1;
    assign br_tgt = pc_inc + PC_W'($signed(imm));
    assign pc_nxt = is_jmp ? ir_q[PC_W-1:0] : (taken ? br_tgt : pc_inc);

    alu_op_t             alu_op;
    logic [DATA_W-1:0]   opnd, alu_res;
    logic                alu_c;
    logic [DATA_W:0]     wide;
    int                  sh;

    assign alu_op = alu_op_t'(opc[3:0]);
    assign opnd   = is_alu_ri ? imm : b_q;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        wide    = '0;
        sh      = int'(imm) % DATA_W;
        case (alu_op)
            ALU_ADD: wide = {1'b0, a_q} + {1'b0, opnd};
            ALU_ADC: wide = {1'b0, a_q} + {1'b0, opnd} + {{DATA_W{1'b0}}, c_q};
            ALU_SUB: wide = {1'b0, a_q} - {1'b0, opnd};
            ALU_SBB: wide = {1'b0, a_q} - {1'b0, opnd} - {{DATA_W{1'b0}}, c_q};
            ALU_AND: wide = {1'b0, a_q & opnd};
            ALU_OR:  wide = {1'b0, a_q | opnd};
            ALU_XOR: wide = {1'b0, a_q ^ opnd};
            ALU_SHL: wide = {1'b0, a_q} << sh;
            ALU_SHR: begin
                wide = {a_q, 1'b0} >> sh;
                wide = {wide[0], wide[DATA_W:1]};
            end
            ALU_ROL: begin
                wide[DATA_W-1:0] = (a_q << sh) | (a_q >> (DATA_W - sh));
                wide[DATA_W]     = wide[0];
            end
            ALU_ROR: begin
                wide[DATA_W-1:0] = (a_q >> sh) | (a_q << (DATA_W - sh));
                wide[DATA_W]     = wide[DATA_W-1];
            end
            default: wide = '0;
        endcase
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
        // A zero-distance shift shifts nothing out, so carry is left alone.
        if (is_shift && sh == 0) alu_c = c_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            c_q          <= 1'b0;
            z_q          <= 1'b0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= DECODE;
                    end
                end
                DECODE: begin
                    a_q     <= rf_rd0;
                    b_q     <= rf_rd1;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (is_alu) begin
                        res_q   <= alu_res;
                        c_q     <= alu_c;
                        z_q     <= (alu_res == '0);
                        state_q <= WB;
                    end else if (is_ld || is_st) begin
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= is_st;
                        dmem_addr_q  <= a_q + imm;
                        dmem_wdata_q <= b_q;
                        state_q      <= MEM;
                    end else if (is_jmp || is_br || is_nop) begin
                        pc_q       <= pc_nxt;
                        imem_req_q <= 1'b1;
                        state_q    <= FETCH;
                    end else begin
                        halted_q  <= 1'b1;
                        illegal_q <= !is_halt;
                        state_q   <= HALT;
                    end
                end
                MEM: begin
                    if (dmem_req_q && dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (is_st) begin
                            pc_q       <= pc_inc;
                            imem_req_q <= 1'b1;
                            state_q    <= FETCH;
                        end else begin
                            res_q   <= dmem_rdata;
                            state_q <= WB;
                        end
                    end
                end
                WB: begin
                    pc_q       <= pc_inc;
                    imem_req_q <= 1'b1;
                    state_q    <= FETCH;
                end
                HALT:    state_q <= HALT;
                default: state_q <= HALT;
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;

`ifdef PERF_COUNTERS_EN
    logic        retire;
    logic [31:0] cyc_q, ret_q;

    assign retire = (state_q == WB)
                 || (state_q == EXEC && (is_jmp || is_br || is_nop || is_halt))
                 || (state_q == MEM && dmem_req_q && dmem_ack && is_st);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != HALT && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
            if (retire && ret_q != '1)          ret_q <= ret_q + 1'b1;
        end
    end

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_data_path.sv
// Directed bench for multicycle_data_path: handshake memory models with
// programmable wait states, two short programs, hand-computed results.
module tb_multicycle_data_path;

    logic        clk, rst;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, illegal;
    logic [11:0] imem_addr;
    logic [19:0] imem_rdata;
    logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;

    multicycle_data_path dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] imem [0:15];
    logic [7:0]  dmem [0:255];
    int iwait, dwait, icnt, dcnt;
    int cyc, n_cmp, n_err, last_t, addr_viol, we_cnt, we_viol;
    logic        prev_ireq, prev_dreq, prev_dwe;
    logic [11:0] prev_iaddr;
    logic [7:0]  prev_daddr;

    function automatic logic [19:0] enc(input logic [5:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [7:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    // Memory responders: ack is raised just after an edge, consumed on the next one.
    initial begin
        imem_ack = 0; imem_rdata = '0; dmem_ack = 0; dmem_rdata = '0; icnt = 0; dcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (imem_ack || !imem_req) begin
                imem_ack = 0; icnt = 0;
            end else if (icnt >= iwait) begin
                imem_ack = 1; imem_rdata = imem[imem_addr[3:0]];
            end else icnt++;
            if (dmem_ack || !dmem_req) begin
                dmem_ack = 0; dcnt = 0;
            end else if (dcnt >= dwait) begin
                dmem_ack = 1;
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                else         dmem_rdata = dmem[dmem_addr];
            end else dcnt++;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (imem_req && prev_ireq && imem_addr != prev_iaddr) addr_viol <= addr_viol + 1;
            if (dmem_req && prev_dreq && (dmem_addr != prev_daddr || dmem_we != prev_dwe))
                addr_viol <= addr_viol + 1;
            if (dmem_we) we_cnt <= we_cnt + 1;
            if (dmem_we && !dmem_req) we_viol <= we_viol + 1;
        end
        prev_ireq <= imem_req; prev_iaddr <= imem_addr;
        prev_dreq <= dmem_req; prev_daddr <= dmem_addr; prev_dwe <= dmem_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_fetch(output logic [11:0] a, output int t);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!(imem_req && imem_ack) && k < 300);
        a = imem_addr; t = cyc;
        if (k >= 300) begin
            n_cmp++; n_err++;
            $error("FAIL fetch_timeout: observed no fetch after %0d cycles", k);
        end
    endtask

    // Next accepted fetch must be at exp_a, exp_c cycles after the previous one.
    task automatic step(input string tag, input logic [11:0] exp_a, input int exp_c);
        logic [11:0] a;
        int t;
        next_fetch(a, t);
        chk({tag, "_addr"}, 32'(a), 32'(exp_a));
        chk({tag, "_cycles"}, t - last_t, exp_c);
        last_t = t;
    endtask

    task automatic wait_halt();
        int k;
        k = 0;
        while (!halted && k < 40) begin @(negedge clk); k++; end
        chk("halted", 32'(halted), 1);
    endtask

    task automatic quiet_check(input string tag);
        int reqs;
        reqs = 0;
        repeat (20) begin @(negedge clk); if (imem_req || dmem_req) reqs++; end
        chk(tag, reqs, 0);
    endtask

    logic [11:0] fa;

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0; addr_viol = 0; we_cnt = 0; we_viol = 0; last_t = 0;
        rst = 0; iwait = 1000; dwait = 0;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        dmem[8'h40] = 8'hF0; dmem[8'h41] = 8'h20;
        for (int i = 0; i < 16; i++) imem[i] = enc(6'h3F, 0, 0, 0);
        imem[0]  = enc(6'h10, 1, 0, 8'h40);   // LD  R1,[R0+40]
        imem[1]  = enc(6'h10, 2, 0, 8'h41);   // LD  R2,[R0+41]
        imem[2]  = enc(6'h00, 3, 1, 8'h02);   // ADD R3,R1,R2
        imem[3]  = enc(6'h01, 4, 0, 8'h00);   // ADC R4,R0,R0
        imem[4]  = enc(6'h11, 1, 0, 8'h7F);   // ST  R1,[R0+7F]
        imem[5]  = enc(6'h10, 6, 0, 8'h7F);   // LD  R6,[R0+7F]
        imem[6]  = enc(6'h02, 5, 1, 8'h01);   // SUB R5,R1,R1
        imem[7]  = enc(6'h18, 0, 0, 8'h09);   // JMP 9
        imem[8]  = enc(6'h25, 7, 1, 8'h00);   // ORI R7,R1,0
        imem[9]  = enc(6'h19, 0, 0, 8'hFE);   // BZ  -2
        imem[10] = enc(6'h2F, 0, 0, 8'h00);   // illegal

        repeat (3) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_dmem_req", 32'(dmem_req), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);

        rst = 1;
        for (int k = 0; k < 10 && !imem_req; k++) @(negedge clk);
        chk("midfetch_req", 32'(imem_req), 1);
        chk("midfetch_addr", 32'(imem_addr), 0);
        #2 rst = 0;
        #1 chk("async_req_drop", 32'(imem_req), 0);
        @(negedge clk);
        iwait = 0; rst = 1;

        next_fetch(fa, last_t);
        chk("p1_f0_addr", 32'(fa), 0);
        step("ld1", 1, 5);
        step("ld2", 2, 5);
        chk("R1", 32'(dut.u_rf.regs_q[1]), 32'hF0);
        chk("R2", 32'(dut.u_rf.regs_q[2]), 32'h20);
        step("add", 3, 4);
        chk("R3", 32'(dut.u_rf.regs_q[3]), 32'h10);
        chk("add_C", 32'(dut.c_q), 1);
        chk("add_Z", 32'(dut.z_q), 0);
        dwait = 2;
        step("adc", 4, 4);
        chk("R4", 32'(dut.u_rf.regs_q[4]), 32'h01);
        chk("adc_C", 32'(dut.c_q), 0);
        step("st_wait2", 5, 6);
        chk("mem_7F", 32'(dmem[8'h7F]), 32'hF0);
        step("ld_wait2", 6, 7);
        chk("R6", 32'(dut.u_rf.regs_q[6]), 32'hF0);
        dwait = 0;
        step("sub", 7, 4);
        chk("R5", 32'(dut.u_rf.regs_q[5]), 32'h00);
        chk("sub_Z", 32'(dut.z_q), 1);
        chk("sub_C", 32'(dut.c_q), 0);
        step("jmp", 9, 3);
        step("bz_taken", 8, 3);
        step("ori", 9, 4);
        chk("R7", 32'(dut.u_rf.regs_q[7]), 32'hF0);
        chk("ori_Z", 32'(dut.z_q), 0);
        step("bz_not_taken", 10, 3);
        wait_halt();
        chk("illegal_flag", 32'(illegal), 1);
        chk("illegal_pc", 32'(imem_addr), 12'h00A);
        quiet_check("illegal_no_req");
        chk("illegal_pc_frozen", 32'(imem_addr), 12'h00A);
        chk("we_cycles", we_cnt, 3);
        chk("we_without_req", we_viol, 0);

        @(negedge clk);
        rst = 0; iwait = 3;
        for (int i = 0; i < 16; i++) imem[i] = enc(6'h3F, 0, 0, 0);
        imem[0] = enc(6'h10, 1, 0, 8'h40);    // LD   R1,[R0+40]  F0
        imem[1] = enc(6'h08, 2, 1, 8'h01);    // SHL  R2,R1,1
        imem[2] = enc(6'h09, 3, 1, 8'h05);    // SHR  R3,R1,5
        imem[3] = enc(6'h0B, 4, 1, 8'h04);    // ROR  R4,R1,4
        imem[4] = enc(6'h08, 5, 1, 8'h08);    // SHL  R5,R1,8 (distance 0)
        imem[5] = enc(6'h22, 6, 0, 8'h01);    // SUBI R6,R0,1
        imem[6] = enc(6'h23, 7, 6, 8'h0F);    // SBBI R7,R6,0F
        imem[7] = enc(6'h0A, 2, 1, 8'h03);    // ROL  R2,R1,3
        imem[8] = enc(6'h3F, 0, 0, 8'h00);    // HALT
        @(negedge clk);
        chk("rst2_illegal_clear", 32'(illegal), 0);
        chk("rst2_halted_clear", 32'(halted), 0);
        chk("rst2_R7_clear", 32'(dut.u_rf.regs_q[7]), 0);
        rst = 1;

        next_fetch(fa, last_t);
        chk("p2_f0_addr", 32'(fa), 0);
        step("ld_slowfetch", 1, 8);
        chk("p2_R1", 32'(dut.u_rf.regs_q[1]), 32'hF0);
        step("shl1", 2, 7);
        chk("shl1_R2", 32'(dut.u_rf.regs_q[2]), 32'hE0);
        chk("shl1_C", 32'(dut.c_q), 1);
        step("shr5", 3, 7);
        chk("shr5_R3", 32'(dut.u_rf.regs_q[3]), 32'h07);
        chk("shr5_C", 32'(dut.c_q), 1);
        step("ror4", 4, 7);
        chk("ror4_R4", 32'(dut.u_rf.regs_q[4]), 32'h0F);
        chk("ror4_C", 32'(dut.c_q), 0);
        step("shl0", 5, 7);
        chk("shl0_R5", 32'(dut.u_rf.regs_q[5]), 32'hF0);
        chk("shl0_C_held", 32'(dut.c_q), 0);
        chk("shl0_Z", 32'(dut.z_q), 0);
        step("subi", 6, 7);
        chk("subi_R6", 32'(dut.u_rf.regs_q[6]), 32'hFF);
        chk("subi_borrow", 32'(dut.c_q), 1);
        step("sbbi", 7, 7);
        chk("sbbi_R7", 32'(dut.u_rf.regs_q[7]), 32'hEF);
        chk("sbbi_C", 32'(dut.c_q), 0);
        step("rol3", 8, 7);
        chk("rol3_R2", 32'(dut.u_rf.regs_q[2]), 32'h87);
        chk("rol3_C", 32'(dut.c_q), 1);
        wait_halt();
        chk("halt_not_illegal", 32'(illegal), 0);
        quiet_check("halt_no_req");
        chk("halt_pc_frozen", 32'(imem_addr), 12'h008);
        chk("req_stability", addr_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
